// File: rtl/key_intr_fifo_pkg.sv
// Shared keypad definitions: key code width, keypad code map and the interrupt FSM encoding.
package key_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT
    } intr_state_t;

    localparam logic [KEY_W-1:0] KEY_0     = 4'h0;
    localparam logic [KEY_W-1:0] KEY_1     = 4'h1;
    localparam logic [KEY_W-1:0] KEY_2     = 4'h2;
    localparam logic [KEY_W-1:0] KEY_3     = 4'h3;
    localparam logic [KEY_W-1:0] KEY_4     = 4'h4;
    localparam logic [KEY_W-1:0] KEY_5     = 4'h5;
    localparam logic [KEY_W-1:0] KEY_6     = 4'h6;
    localparam logic [KEY_W-1:0] KEY_7     = 4'h7;
    localparam logic [KEY_W-1:0] KEY_8     = 4'h8;
    localparam logic [KEY_W-1:0] KEY_9     = 4'h9;
    localparam logic [KEY_W-1:0] KEY_STAR  = 4'hA;
    localparam logic [KEY_W-1:0] KEY_POUND = 4'hB;

endpackage

// File: rtl/key_intr_fifo_if.sv
// Scanner-side key event and MCU-side IN-port/interrupt signals of the key FIFO.
interface key_intr_fifo_if #(
    parameter int DEPTH = 4
);
    logic                       PRESS;
    logic [key_pkg::KEY_W-1:0]  DATA;
    logic                       RD;
    logic                       CLR_OVF;
    logic [7:0]                 DOUT;
    logic [$clog2(DEPTH):0]     COUNT;
    logic                       EMPTY;
    logic                       FULL;
    logic                       OVF;
    logic                       INTR;

    modport master (
        output PRESS, DATA, RD, CLR_OVF,
        input  DOUT, COUNT, EMPTY, FULL, OVF, INTR
    );

    modport slave (
        input  PRESS, DATA, RD, CLR_OVF,
        output DOUT, COUNT, EMPTY, FULL, OVF, INTR
    );
endinterface

// File: rtl/key_intr_fifo_sync_edge.sv
// Two-flop synchronizer for an asynchronous level, followed by a one-cycle rising-edge pulse.
module sync_edge (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic async_i,
    output logic rise_o
);
    logic meta_q;
    logic sync_q;
    logic dly_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            dly_q  <= 1'b0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            dly_q  <= sync_q;
        end
    end

    assign rise_o = sync_q & ~dly_q;
endmodule

// File: rtl/key_intr_fifo.sv
// Buffers keypad codes in a small FIFO and raises one fixed-width INTR pulse per buffered key.
module key_intr_fifo
    import key_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int INTR_LEN = 3
) (
    input logic            CLK,
    input logic            RST_N,
    key_intr_fifo_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int ICNT_W = $clog2(INTR_LEN) + 1;

    logic              push;
    logic              empty;
    logic              full;
    logic              do_push;
    logic              do_pop;
    logic              drop;

    logic [KEY_W-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              ovf_q, ovf_d;

    intr_state_t       state_q, state_d;
    logic [ICNT_W-1:0] icnt_q, icnt_d;
    logic              rd_seen_q, rd_seen_d;
    logic              intr;

    sync_edge u_press_edge (
        .clk_i  (CLK),
        .rst_ni (RST_N),
        .async_i(bus.PRESS),
        .rise_o (push)
    );

    assign empty   = (count_q == '0);
    assign full    = (count_q == CNT_W'(DEPTH));
    // A pop frees a slot in the same cycle, so a push at full still lands.
    assign do_pop  = bus.RD && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (drop)             ovf_d = 1'b1;
        else if (bus.CLR_OVF) ovf_d = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (do_push) mem_q[wr_ptr_q] <= bus.DATA;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            icnt_q    <= '0;
            rd_seen_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            icnt_q    <= icnt_d;
            rd_seen_q <= rd_seen_d;
        end
    end

    // A read during the pulse already acknowledged it, so skip WAIT and re-arm via IDLE.
    always_comb begin
        state_d   = state_q;
        icnt_d    = icnt_q;
        rd_seen_d = rd_seen_q;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    state_d   = PULSE;
                    icnt_d    = ICNT_W'(INTR_LEN - 1);
                    rd_seen_d = 1'b0;
                end
            end
            PULSE: begin
                if (icnt_q == '0) begin
                    state_d = (rd_seen_q || bus.RD) ? IDLE : WAIT;
                end else begin
                    icnt_d    = icnt_q - ICNT_W'(1);
                    rd_seen_d = rd_seen_q | bus.RD;
                end
            end
            WAIT: begin
                if (bus.RD) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        intr = (state_q == PULSE);
    end

    assign bus.DOUT  = empty ? 8'h00 : {{(8 - KEY_W){1'b0}}, mem_q[rd_ptr_q]};
    assign bus.COUNT = count_q;
    assign bus.EMPTY = empty;
    assign bus.FULL  = full;
    assign bus.OVF   = ovf_q;
    assign bus.INTR  = intr;
endmodule

// File: doc/key_intr_fifo.md
Name: key_intr_fifo

Overview:
- Sits directly downstream of the keypad scanner; consumes its PRESS/DATA key events.
- Buffers key codes in a small FIFO and raises a fixed-width INTR pulse to the MCU per buffered key.
- The MCU ISR reads the oldest code through an IN port and pops it with a read strobe.
- Replaces the unbuffered single-register capture, so fast typing no longer drops keys.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- INTR_LEN, 3, CLK cycles INTR stays high per interrupt; >=1.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset; asynchronous assert, active-low.
- PRESS  in  1  key-held level from the scanner; scanner clock domain, asynchronous to CLK.
- DATA  in  4  key code from the scanner; stable while PRESS is high.
- RD  in  1  one-cycle pop strobe from the MCU IN-port decode.
- CLR_OVF  in  1  one-cycle strobe; clears OVF.
- DOUT  out  8  {4'h0, head entry}; 8'h00 when empty.
- COUNT  out  $clog2(DEPTH)+1  occupancy.
- EMPTY  out  1  COUNT==0.
- FULL  out  1  COUNT==DEPTH.
- OVF  out  1  sticky: a key was dropped because the FIFO was full.
- INTR  out  1  interrupt pulse to the MCU.

Behaviour:
- Reset (RST_N low, async): pointers=0, COUNT=0, EMPTY=1, FULL=0, OVF=0, INTR=0, DOUT=8'h00, FSM=IDLE, synchronizer flops=0.
- PRESS path:
  - Two-flop synchronizer, then a rising-edge detector, producing push = s1 & ~s2.
  - On push, DATA is sampled directly. DATA is held stable for many CLK cycles before and during PRESS, so DATA is not synchronized.
  - Key-event latency: PRESS rise to COUNT update is 3 CLK cycles.
  - A held key produces exactly one push.
- Push/pop rules, evaluated each cycle:
  - Push, not full: write at wr_ptr, wr_ptr++ (wraps mod DEPTH), COUNT++.
  - Push while full, no pop: drop the key, OVF<=1, no other state change.
  - Push while full with pop in the same cycle: both happen; COUNT unchanged; OVF unchanged.
  - Pop (RD) while not empty: rd_ptr++ (wraps), COUNT--.
  - RD while empty: ignored, no underflow.
  - Push and pop on an empty FIFO: push only; RD is ignored.
  - CLR_OVF in the same cycle as a dropping push: OVF=1 (the set wins).
- DOUT is combinational from the head entry; it changes the cycle after a pop.
- INTR FSM:
  - IDLE: if COUNT!=0, go to PULSE and load the counter with INTR_LEN-1; INTR=0.
  - PULSE: INTR=1; counter decrements; at 0, go to WAIT. RD here is honoured as a pop, and the FSM goes to IDLE after the pulse completes instead of WAIT.
  - WAIT: INTR=0; on RD go to IDLE.
  - A non-empty FIFO therefore re-interrupts, with at least one IDLE cycle between pulses. This guarantees the MCU sees a distinct rising edge.
  - Exactly one interrupt is issued per pop cycle, never two pulses for one key.
- Reset mid-pulse: INTR drops immediately (async) and the FIFO contents are lost.

Decomposition:
- Package key_pkg holds:
  - typedef enum logic [1:0] {IDLE, PULSE, WAIT} intr_state_t;
  - localparam KEY_W = 4;
  - the keypad code constants (0-9, STAR=4'hA, POUND=4'hB) shared with the scanner and the ISR test assembly.
- Sub-module sync_edge (2-flop synchronizer plus rising-edge pulse) is natural, since it is reused by other asynchronous inputs.
- FIFO storage and the FSM stay in this module.

Test Plan:
- Reset then a single key: PRESS high for 50 cycles, DATA=4'h5 -> push 3 cycles after the rise; COUNT=1; DOUT=8'h05; INTR high for exactly 3 cycles; FSM in WAIT; after RD, COUNT=0, DOUT=8'h00, no further INTR.
- Burst without reads: keys 1,2,3,4 pressed -> FULL=1, only one INTR pulse total. Pressing 7 next -> OVF=1 and FIFO still holds 1,2,3,4. CLR_OVF -> OVF=0.
- Drain order: from the full state, issue RD once per WAIT -> DOUT sequence 01,02,03,04; four INTR pulses separated by at least one low cycle; EMPTY after the last pop.
- Simultaneous push and pop at full: RD on the exact push cycle of key 9 -> COUNT stays 4, OVF=0, head advances, tail becomes 9.
- Held key and RD while empty: PRESS held for 1000 cycles -> exactly one entry. RD strobes while empty -> COUNT stays 0, pointers do not move.
- Async reset during PULSE: RST_N low in the second INTR cycle -> INTR=0 within the same cycle; COUNT=0; OVF=0; after release, no INTR until the next key.
